// File: rtl/alu_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_drain
//  Brief    : Circular result queue between the ALU result register and the
//             register-file write port. Accepts {rd, value} pairs, retires
//             one per cycle when the register file is not stalled, and
//             offers a combinational forwarding lookup into in-flight
//             entries (newest matching entry wins).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_drain #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    // ALU result side
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    // Register-file write side
    input  logic                     wb_stall,
    output logic                     wb_en,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    // Forwarding lookup
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    // Status
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage
    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Slot index of the k-th oldest entry, counting from head
    logic [PTR_W-1:0]  w_idx [DEPTH];

    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Occupancy flags come from the counter only; head==tail is ambiguous
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);

    // A $0 result completes its handshake but is never stored
    assign w_push   = in_valid && !w_full && (in_rd != '0);
    assign w_pop    = !w_empty && !wb_stall;

    assign in_ready = !w_full;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;

    assign wb_en    = w_pop;
    assign wb_addr  = w_pop ? r_rd[r_head]   : '0;
    assign wb_data  = w_pop ? r_data[r_head] : '0;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_idx
            assign w_idx[g] = r_head + PTR_W'(g);
        end
    endgenerate

    // Entry storage: write at tail on push, clear valid at head on pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_rd[r_tail]   <= in_rd;
                r_data[r_tail] <= in_data;
                r_vld[r_tail]  <= 1'b1;
            end
        end
    end

    // Head/tail pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
        end
    end

    // Occupancy counter: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Forwarding: scan oldest to newest so the newest match overrides
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (fwd_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r_vld[w_idx[k]] && (r_rd[w_idx[k]] == fwd_addr)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_data[w_idx[k]];
                end
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_drain
//  Brief    : Self-checking bench for alu_result_drain: directed vector table,
//             hand-written multi-cycle sequences, and randomized traffic
//             compared against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_drain;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              wb_stall;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_drain #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .wb_stall (wb_stall),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: a plain FIFO of results -------------
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_full;
    bit   m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && !wb_stall;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && !m_full && in_rd != 0) mq.push_back('{in_rd, in_data});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against what the model says this cycle
    task automatic model_check();
        logic              e_wb;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic              e_hit;
        logic [DATA_W-1:0] e_fd;
        int                sz;
        sz    = mq.size();
        e_wb  = (sz != 0) && !wb_stall;
        e_wa  = e_wb ? mq[0].rd : '0;
        e_wd  = e_wb ? mq[0].d  : '0;
        e_hit = 1'b0;
        e_fd  = '0;
        if (fwd_addr != 0) begin
            for (int k = sz - 1; k >= 0; k--) begin
                if (!e_hit && mq[k].rd == fwd_addr) begin
                    e_hit = 1'b1;
                    e_fd  = mq[k].d;
                end
            end
        end
        chk("rnd_count",    64'(count),    64'(sz));
        chk("rnd_in_ready", 64'(in_ready), 64'(sz != DEPTH));
        chk("rnd_wb_en",    64'(wb_en),    64'(e_wb));
        chk("rnd_wb_addr",  64'(wb_addr),  64'(e_wa));
        chk("rnd_wb_data",  64'(wb_data),  64'(e_wd));
        chk("rnd_fwd_hit",  64'(fwd_hit),  64'(e_hit));
        chk("rnd_fwd_data", 64'(fwd_data), 64'(e_fd));
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] d, input logic st,
                         input logic [ADDR_W-1:0] fa);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        wb_stall = st;
        fwd_addr = fa;
    endtask

    // Inputs change 1 time unit after posedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
        logic              st;
        logic [ADDR_W-1:0] fa;
        logic [2:0]        e_cnt;
        logic              e_wb;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic              e_hit;
        logic [DATA_W-1:0] e_fd;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    initial begin
        // single result: push, write next cycle, then empty
        tv[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 3'd1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tv[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        // $0 filter
        tv[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[4]  = '{1'b1, 5'd2, 32'h5,        1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd2, 3'd1, 1'b1, 5'd2, 32'h5,        1'b1, 32'h5};
        tv[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd2, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        // forwarding under stall, then drain
        tv[7]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[8]  = '{1'b1, 5'd7, 32'h22,       1'b1, 5'd7, 3'd1, 1'b0, 5'd0, 32'h0,        1'b1, 32'h11};
        tv[9]  = '{1'b1, 5'd9, 32'h33,       1'b1, 5'd7, 3'd2, 1'b0, 5'd0, 32'h0,        1'b1, 32'h22};
        tv[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 3'd3, 1'b0, 5'd0, 32'h0,        1'b1, 32'h22};
        tv[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 3'd3, 1'b0, 5'd0, 32'h0,        1'b1, 32'h33};
        tv[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 3'd3, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 3'd3, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 3'd3, 1'b1, 5'd7, 32'h11,       1'b1, 32'h22};
        tv[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 3'd2, 1'b1, 5'd7, 32'h22,       1'b1, 32'h22};
        tv[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 3'd1, 1'b1, 5'd9, 32'h33,       1'b0, 32'h0};
        tv[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 3'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
    end

    // ---------------- main sequence ----------------------------------------
    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        #2;
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_full",     64'(full),     64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb",       64'({wb_en, wb_addr, wb_data}), 64'd0);
        chk("rst_fwd",      64'({fwd_hit, fwd_data}),       64'd0);
        next_cycle();
        reset = 1'b0;

        // directed table, one row per cycle
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].v, tv[i].rd, tv[i].d, tv[i].st, tv[i].fa);
            @(negedge clk);
            chk($sformatf("vec%0d_count", i),    64'(count),    64'(tv[i].e_cnt));
            chk($sformatf("vec%0d_wb_en", i),    64'(wb_en),    64'(tv[i].e_wb));
            chk($sformatf("vec%0d_wb_addr", i),  64'(wb_addr),  64'(tv[i].e_wa));
            chk($sformatf("vec%0d_wb_data", i),  64'(wb_data),  64'(tv[i].e_wd));
            chk($sformatf("vec%0d_fwd_hit", i),  64'(fwd_hit),  64'(tv[i].e_hit));
            chk($sformatf("vec%0d_fwd_data", i), 64'(fwd_data), 64'(tv[i].e_fd));
            next_cycle();
        end

        // full under stall; fifth push dropped, also while the first pop happens
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, '0);
            next_cycle();
        end
        drive(1'b1, 5'd5, 32'h105, 1'b1, 5'd5);
        @(negedge clk);
        chk("full_flag",     64'(full),     64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count",    64'(count),    64'd4);
        chk("full_wb_en",    64'(wb_en),    64'd0);
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(i == 1, 5'd5, 32'h105, 1'b0, 5'd5);
            @(negedge clk);
            if (i == 1) chk("full_pop_in_ready", 64'(in_ready), 64'd0);
            chk($sformatf("drain%0d_wb_en", i),   64'(wb_en),   64'd1);
            chk($sformatf("drain%0d_wb_addr", i), 64'(wb_addr), 64'(i));
            chk($sformatf("drain%0d_wb_data", i), 64'(wb_data), 64'h100 + 64'(i));
            chk($sformatf("drain%0d_no_rd5", i),  64'(fwd_hit), 64'd0);
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("drain_done_wb_en", 64'(wb_en), 64'd0);
        chk("drain_done_empty", 64'(empty), 64'd1);
        next_cycle();

        // streaming through pointer wrap: 3*DEPTH results, one in one out
        for (int i = 0; i <= 3 * DEPTH; i++) begin
            drive(i < 3 * DEPTH, 5'((i % 31) + 1), 32'(i), 1'b0, '0);
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("stream%0d_wb_en", i),   64'(wb_en),   64'd1);
                chk($sformatf("stream%0d_wb_data", i), 64'(wb_data), 64'(i - 1));
                chk($sformatf("stream%0d_count", i),   64'(count),   64'd1);
            end
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("stream_end_empty", 64'(empty), 64'd1);
        next_cycle();

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(4 + i), 32'hA0 + 32'(i), 1'b1, '0);
            next_cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 5'd4);
        @(negedge clk);
        chk("pre_rst_count", 64'(count),   64'd3);
        chk("pre_rst_hit",   64'(fwd_hit), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_empty",    64'(empty),    64'd1);
        chk("mid_rst_count",    64'(count),    64'd0);
        chk("mid_rst_wb_en",    64'(wb_en),    64'd0);
        chk("mid_rst_fwd_hit",  64'(fwd_hit),  64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        reset    = 1'b0;
        wb_stall = 1'b0;
        @(negedge clk);
        chk("post_rst_wb_en", 64'(wb_en), 64'd0);
        chk("post_rst_count", 64'(count), 64'd0);
        next_cycle();

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)));
            @(negedge clk);
            model_check();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
